// File: rtl/seq_nr_divider_pkg.sv
// Shared definitions for the sequential non-restoring divider: FSM encoding,
// default operand width and the iteration-counter width helper.
package seq_nr_divider_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_nr_divider_addsub.sv
// N-bit ripple-carry add/subtract cell: o_sum = i_a + (i_b ^ {N{i_sub}}) + i_sub.
// The carry out of the top bit is never formed.
module seq_nr_divider_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_sub,
    output logic [N-1:0] o_sum
);

    logic [N-1:0] w_b;
    logic [N-1:0] w_c;

    assign w_b    = i_b ^ {N{i_sub}};
    assign w_c[0] = i_sub;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign o_sum[gi] = i_a[gi] ^ w_b[gi] ^ w_c[gi];
            if (gi < N - 1) begin : g_carry
                assign w_c[gi+1] = (i_a[gi] & w_b[gi]) | (w_c[gi] & (i_a[gi] ^ w_b[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/seq_nr_divider.sv
// Multi-cycle non-restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_SIGNED_EN: two's-complement operands with truncation toward zero.
module seq_nr_divider
    import seq_nr_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;
    logic             w_div_zero;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_as_a;
    logic [WIDTH:0]   w_sum;
    logic             w_as_sub;
    logic [WIDTH-1:0] w_rem_base;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_div_zero = (divisor == '0);

    // ITER: shifted partial remainder +/- D; FIX: P + D (used only when P is negative).
    assign w_as_a   = (r_state == S_FIX) ? r_p : {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_as_sub = (r_state == S_FIX) ? 1'b0 : ~r_p[WIDTH];

    seq_nr_divider_addsub #(
        .N (WIDTH + 1)
    ) u_addsub (
        .i_a   (w_as_a),
        .i_b   ({1'b0, r_d}),
        .i_sub (w_as_sub),
        .o_sum (w_sum)
    );

    assign w_rem_base = r_p[WIDTH] ? w_sum[WIDTH-1:0] : r_p[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_mag  = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    assign w_dvs_mag  = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
    assign w_quot_fix = r_neg_q ? ('0 - r_q) : r_q;
    assign w_rem_fix  = r_neg_r ? ('0 - w_rem_base) : w_rem_base;
`else
    assign w_dvd_mag  = dividend;
    assign w_dvs_mag  = divisor;
    assign w_quot_fix = r_q;
    assign w_rem_fix  = w_rem_base;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_div_zero ? S_DONE : S_ITER;
                end
            end
            S_ITER:  if (r_cnt == '0) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_p    <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_dbz <= w_div_zero;
                if (w_div_zero) begin
                    r_quot <= '1;
                    r_rem  <= dividend;
                end else begin
                    r_d   <= w_dvs_mag;
                    r_q   <= w_dvd_mag;
                    r_p   <= '0;
                    r_cnt <= CNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                    r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg_r <= dividend[WIDTH-1];
`endif
                end
            end
            if (r_state == S_ITER) begin
                r_p   <= w_sum;
                r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
                r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == S_FIX) begin
                r_quot <= w_quot_fix;
                r_rem  <= w_rem_fix;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_nr_divider.sv
// Self-checking bench for seq_nr_divider: directed vectors, random operands against an
// arithmetic reference model, handshake corner cases and mid-operation reset.
module tb_seq_nr_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_nr_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division (truncating), remainder sign follows dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int sa;
        int sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            q = W'(sa / sb);
            r = W'(sa % sb);
            z = 1'b0;
        end
    endfunction

    // Stimulus driver: call #1 after an edge with the DUT idle. cyc is the cycle in which
    // done rose, counting the accepting cycle as 0 (-1 on timeout).
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                           output int cyc, output logic busy_acc, output logic done_after);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        busy_acc = busy;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (done !== 1'b1) cyc = -1;
        q = quotient;
        r = remainder;
        z = div_by_zero;
        @(posedge clk); #1;
        done_after = done;
        $display("[TB] %0d / %0d -> q=%0d r=%0d dbz=%0b done in cycle %0d", a, b, q, r, z, cyc);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b q=%h r=%h dbz=%b required all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_directed();
        int ta [6] = '{100, 255, 5, 0, 37, 255};
        int tb [6] = '{7,   1,   9, 3, 0,  255};
        int tq [6] = '{14,  255, 0, 0, 255, 1};
        int tr [6] = '{2,   0,   5, 0, 37, 0};
        int tz [6] = '{0,   0,   0, 0, 1,  0};
        logic [W-1:0] q, r;
        logic z, ba, da;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            run_div(W'(ta[i]), W'(tb[i]), q, r, z, cyc, ba, da);
            n_tests++;
            if ({q, r, z} !== {W'(tq[i]), W'(tr[i]), tz[i] != 0}) begin
                n_fail++;
                $display("FAIL directed_%0d: q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0d",
                         i, q, r, z, tq[i], tr[i], tz[i]);
            end
            n_tests++;
            if (cyc != ((tb[i] == 0) ? 1 : W + 2)) begin
                n_fail++;
                $display("FAIL latency_%0d: done in cycle %0d required %0d",
                         i, cyc, (tb[i] == 0) ? 1 : W + 2);
            end
            n_tests++;
            if (ba !== 1'b1 || da !== 1'b0) begin
                n_fail++;
                $display("FAIL handshake_%0d: busy_after_accept=%b done_next=%b required 1,0",
                         i, ba, da);
            end
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int ta [3] = '{8'h9C, 100,   8'h80};
        int tb [3] = '{7,     8'hF9, 8'hFF};
        int tq [3] = '{8'hF2, 8'hF2, 8'h80};
        int tr [3] = '{8'hFE, 2,     0};
        logic [W-1:0] q, r;
        logic z, ba, da;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            run_div(W'(ta[i]), W'(tb[i]), q, r, z, cyc, ba, da);
            n_tests++;
            if ({q, r, z, cyc} !== {W'(tq[i]), W'(tr[i]), 1'b0, W + 2}) begin
                n_fail++;
                $display("FAIL signed_%0d: q=%h r=%h dbz=%0b cyc=%0d required q=%h r=%h dbz=0 cyc=%0d",
                         i, q, r, z, cyc, tq[i], tr[i], W + 2);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic z, ez, ba, da;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 15) == 0) begin
                a = {1'b1, {(W-1){1'b0}}};
                b = '1;
            end
            model(a, b, eq, er, ez);
            run_div(a, b, q, r, z, cyc, ba, da);
            n_tests++;
            if ({q, r, z} !== {eq, er, ez}) begin
                n_fail++;
                $display("FAIL random_%0d (%0d/%0d): q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b",
                         i, a, b, q, r, z, eq, er, ez);
            end
            n_tests++;
            if (cyc != (ez ? 1 : W + 2) || da !== 1'b0) begin
                n_fail++;
                $display("FAIL random_timing_%0d: done cycle=%0d next_done=%b required %0d,0",
                         i, cyc, da, ez ? 1 : W + 2);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [W-1:0] eq, er, q, r;
        logic ez, z;
        int dones = 0;
        int cyc = -1;
        model(W'(100), W'(7), eq, er, ez);
        start = 1'b1; dividend = W'(100); divisor = W'(7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; dividend = W'(50); divisor = W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        q = '0; r = '0; z = 1'b0;
        for (int c = 4; c < 20; c++) begin
            if (done === 1'b1) begin
                dones++;
                if (cyc < 0) begin
                    cyc = c;
                    q = quotient; r = remainder; z = div_by_zero;
                end
            end
            @(posedge clk); #1;
        end
        $display("[TB] start-while-busy: q=%0d r=%0d done pulses=%0d first at cycle %0d", q, r, dones, cyc);
        n_tests++;
        if ({q, r, z} !== {eq, er, ez}) begin
            n_fail++;
            $display("FAIL start_busy_result: q=%0d r=%0d dbz=%0b required q=%0d r=%0d dbz=%0b",
                     q, r, z, eq, er, ez);
        end
        n_tests++;
        if (dones != 1 || cyc != W + 2) begin
            n_fail++;
            $display("FAIL start_busy_pulses: pulses=%0d cycle=%0d required 1 at %0d", dones, cyc, W + 2);
        end
    endtask

    task automatic test_start_in_done();
        logic [W-1:0] eq, er;
        logic ez;
        int n = 0;
        int dones = 0;
        model(W'(60), W'(7), eq, er, ez);
        start = 1'b1; dividend = W'(60); divisor = W'(7);
        @(posedge clk); #1;
        start = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b1; dividend = W'(9); divisor = W'(2);
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done_busy: busy=%b required 0", busy);
        end
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        $display("[TB] start-in-done: q=%0d r=%0d extra done pulses=%0d", quotient, remainder, dones);
        n_tests++;
        if (dones != 0 || {quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
            n_fail++;
            $display("FAIL start_in_done_ignored: pulses=%0d q=%0d r=%0d required 0 pulses q=%0d r=%0d",
                     dones, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r, eq, er;
        logic z, ez, ba, da;
        int cyc;
        int dones = 0;
        start = 1'b1; dividend = W'(100); divisor = W'(7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("[TB] reset mid-operation: busy=%b done=%b q=%0d r=%0d", busy, done, quotient, remainder);
        n_tests++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b q=%h r=%h dbz=%b required all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: pulses=%0d required 0", dones);
        end
        model(W'(200), W'(9), eq, er, ez);
        run_div(W'(200), W'(9), q, r, z, cyc, ba, da);
        n_tests++;
        if ({q, r, z} !== {eq, er, ez} || cyc != W + 2) begin
            n_fail++;
            $display("FAIL reset_mid_recover: q=%0d r=%0d cyc=%0d required q=%0d r=%0d cyc=%0d",
                     q, r, cyc, eq, er, W + 2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        test_start_while_busy();
        test_start_in_done();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
